// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects a start bit on an oversampled serial line,
// samples the data bits LSB-first at the middle of each bit, checks the stop
// bit and hands the byte to a consumer through a valid/ready register.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   baud       - one-cycle tick, OVERSAMPLING ticks per bit period
//   rx         - synchronized serial input, idle high
//   data_ready - consumer accepts data this cycle
//   data       - last received word, held while data_valid is 1
//   data_valid - data holds an unconsumed word
//   busy       - a frame is in progress
//   frame_err  - one-cycle pulse when the stop bit samples 0
//   overrun    - one-cycle pulse when a good word is dropped
//
// OVERSAMPLING must be even and >= 2; DATA_BITS must be >= 2.
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLING = 4,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TICK_W = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLING / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 deliver;

    // Next-state, sampling and handshake logic
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        if (baud) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    // Mid-start-bit check filters glitches as false starts
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        if (!rx) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        if (rx) begin
                            deliver = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A delivery wins over an accept; a full, unaccepted register drops it
        if (deliver) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames followed by randomized frames,
// all checked every clock against a frame-position reference model.
module tb_uart_rx_ctrl;

    localparam int OS = 4;
    localparam int DB = 8;
    localparam int STOP_POS = OS / 2 + OS * (DB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          baud = 1'b0;
    logic          rx = 1'b1;
    logic          data_ready = 1'b0;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    uart_rx_ctrl #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud       (baud),
        .rx         (rx),
        .data_ready (data_ready),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position in ticks since start detection (-1 = idle)
    int            m_pos = -1;
    logic [DB-1:0] m_bits = '0;
    logic [DB-1:0] exp_data = '0;
    logic          exp_valid = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_ferr = 1'b0;
    logic          exp_ovr = 1'b0;
    bit            gap_rdy_en = 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_busy"},  32'(busy),       32'(exp_busy));
        chk({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
        chk({tag, "_data"},  32'(data),       32'(exp_data));
        chk({tag, "_ferr"},  32'(frame_err),  32'(exp_ferr));
        chk({tag, "_ovr"},   32'(overrun),    32'(exp_ovr));
    endtask

    task automatic model_reset();
        m_pos = -1; m_bits = '0; exp_data = '0; exp_valid = 1'b0;
        exp_busy = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    endtask

    // Effect of one baud tick with line value r and ready rdy
    task automatic model_tick(input logic r, input logic rdy);
        bit deliver = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (m_pos < 0) begin
            if (!r) m_pos = 0;
        end else begin
            m_pos++;
            if (m_pos == OS / 2) begin
                if (r) m_pos = -1;
            end else if (m_pos == STOP_POS) begin
                m_pos = -1;
                if (r) deliver = 1'b1; else exp_ferr = 1'b1;
            end else if ((m_pos - OS / 2) % OS == 0) begin
                m_bits[(m_pos - OS / 2) / OS - 1] = r;
            end
        end
        if (deliver) begin
            if (!exp_valid || rdy) begin
                exp_data  = m_bits;
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        exp_busy = (m_pos >= 0);
    endtask

    // One baud period: tick cycle then OS-1 idle cycles with line noise
    task automatic do_tick(input logic r, input logic rdy);
        logic g;
        @(negedge clk);
        check_all("tick");
        baud = 1'b1; rx = r; data_ready = rdy;
        model_tick(r, rdy);
        for (int c = 1; c < OS; c++) begin
            @(negedge clk);
            check_all("gap");
            g = gap_rdy_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            baud = 1'b0; rx = 1'($urandom); data_ready = g;
            exp_ferr = 1'b0; exp_ovr = 1'b0;
            if (exp_valid && g) exp_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input logic rdy_dlv);
        for (int t = 0; t < OS; t++) do_tick(1'b0, 1'b0);
        for (int k = 0; k < DB; k++)
            for (int t = 0; t < OS; t++) do_tick(b[k], 1'b0);
        for (int t = 0; t < OS; t++) do_tick(stop, (t == OS / 2) ? rdy_dlv : 1'b0);
    endtask

    // Reset with baud and data_ready also asserted to show reset priority
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; baud = 1'b1; rx = 1'b0; data_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; baud = 1'b0; rx = 1'b1; data_ready = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        logic [DB-1:0] rb;
        do_reset();
        chk("reset_busy_const", 32'(busy), 32'd0);
        chk("reset_valid_const", 32'(data_valid), 32'd0);
        repeat (2) do_tick(1'b1, 1'b0);

        // Basic frame, consumer not ready
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_valid", 32'(data_valid), 32'd1);
        do_tick(1'b1, 1'b1);
        chk("a5_accept", 32'(data_valid), 32'd0);

        // Glitch on the line: false start
        do_tick(1'b0, 1'b0);
        chk("fs_busy_set", 32'(busy), 32'd1);
        repeat (3) do_tick(1'b1, 1'b0);
        chk("fs_busy_clr", 32'(busy), 32'd0);
        chk("fs_valid", 32'(data_valid), 32'd0);

        // Framing error then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("fe_valid", 32'(data_valid), 32'd0);
        do_tick(1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        chk("fe_next_data", 32'(data), 32'h11);
        do_tick(1'b1, 1'b1);

        // Back-to-back frames with no consumer: overrun
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        chk("ovr_hold", 32'(data), 32'h12);
        do_tick(1'b1, 1'b1);
        chk("ovr_cleared", 32'(data_valid), 32'd0);

        // Accept on the delivery cycle: new byte replaces old, no overrun
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1);
        chk("same_cyc_data", 32'(data), 32'h34);
        chk("same_cyc_valid", 32'(data_valid), 32'd1);
        do_tick(1'b1, 1'b1);

        // Reset in the middle of bit 4, then a clean frame
        for (int t = 0; t < OS; t++) do_tick(1'b0, 1'b0);
        for (int t = 0; t < OS * 4 + 2; t++) do_tick(1'($urandom), 1'b0);
        do_reset();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        repeat (2) do_tick(1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("post_rst_data", 32'(data), 32'h5A);
        do_tick(1'b1, 1'b1);

        // Randomized traffic
        gap_rdy_en = 1'b1;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_tick(1'b0, 1'b0);
                repeat (2) do_tick(1'b1, 1'b0);
            end
            rb = DB'($urandom);
            send_frame(rb, 1'($urandom_range(0, 5) != 0), 1'($urandom));
            repeat ($urandom_range(0, 2)) do_tick(1'b1, 1'($urandom));
        end
        @(negedge clk);
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
